// File: rtl/drop_controller_pkg.sv
// drop_controller_pkg: shared grid geometry, off-grid sentinels and FSM/move encodings
package drop_controller_pkg;
    localparam int COLS     = 10;
    localparam int ROWS     = 20;
    localparam int CELL     = 20;
    localparam int X_ORIGIN = 240;
    localparam int Y_ROW0   = 60;
    localparam logic [4:0] COL_OFF = 5'd10;
    localparam logic [4:0] ROW_OFF = 5'd20;
    typedef enum logic [2:0] {IDLE, SPAWN_CHK, READY, CHK_MOVE, LOCK, OVER} state_t;
    typedef enum logic [1:0] {MV_FALL, MV_LEFT, MV_RIGHT} move_t;
endpackage

// File: rtl/position_counter.sv
// position_counter: maps square pixel coordinates to grid column/row, sentinel when off-grid
module position_counter
    import drop_controller_pkg::*;
(
    input  logic [9:0] sq2,
    input  logic [9:0] sq0,
    output logic [4:0] pos0,
    output logic [4:0] pos1
);
    logic [9:0] dx, dy;
    // offset from the grid origin, then divide by the cell pitch when inside the grid
    always_comb begin
        dx   = sq2 - 10'(X_ORIGIN);
        dy   = sq0 - 10'(Y_ROW0);
        pos0 = (sq2 >= 10'(X_ORIGIN) && dx < 10'(COLS * CELL)) ? 5'(dx / 10'(CELL)) : COL_OFF;
        pos1 = (sq0 >= 10'(Y_ROW0) && dy < 10'(ROWS * CELL)) ? 5'(dy / 10'(CELL)) : ROW_OFF;
    end
endmodule

// File: rtl/drop_controller.sv
// drop_controller: falling-square sequencer with gravity, occupancy-checked moves and lock/respawn
module drop_controller
    import drop_controller_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int SPAWN_X  = 320,
    parameter int SPAWN_Y  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    output logic [9:0] sq_x,
    output logic [9:0] sq_y,
    output logic [4:0] col,
    output logic [4:0] row,
    output logic       occ_req,
    output logic [4:0] occ_row,
    output logic [4:0] occ_col,
    input  logic       occ_valid,
    input  logic       occ_hit,
    output logic       lock_valid,
    output logic [4:0] lock_row,
    output logic [4:0] lock_col,
    input  logic       lock_ready,
    output logic       game_over,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t        state, state_nx;
    move_t         mv, pick;
    logic [TW-1:0] tick_cnt;
    logic          pend_fall, pend_l, pend_r;
    logic [4:0]    tgt_row, tgt_col, nrow, ncol;
    logic          spawn, consume, do_latch, commit;
    logic          tick, set_fall, set_l, set_r;

    position_counter u_pos (.sq2(sq_x), .sq0(sq_y), .pos0(col), .pos1(row));

    assign busy       = state != IDLE && state != OVER;
    assign game_over  = state == OVER;
    assign occ_req    = state == SPAWN_CHK || state == CHK_MOVE;
    assign occ_row    = state == CHK_MOVE ? tgt_row : row;
    assign occ_col    = state == CHK_MOVE ? tgt_col : col;
    assign lock_valid = state == LOCK;
    assign lock_row   = row;
    assign lock_col   = col;
    assign tick       = busy && !btn_down && tick_cnt == TW'(TICK_DIV - 1);
    assign set_fall   = busy && (btn_down || tick);
    assign set_l      = busy && btn_left && !btn_right;
    assign set_r      = busy && btn_right && !btn_left;

    // gravity counter: free-runs while a piece is in play, soft drop restarts the period
    always_ff @(posedge clk) begin
        if (rst || set_fall) tick_cnt <= '0;
        else if (busy) tick_cnt <= tick_cnt + 1'b1;
    end

    // one-deep pending events; a new request in the consume cycle survives
    always_ff @(posedge clk) begin
        if (rst || spawn) begin
            pend_fall <= 1'b0;
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
        end else begin
            pend_fall <= set_fall || (pend_fall && !(consume && pick == MV_FALL));
            pend_l    <= set_l || (pend_l && !(consume && pick == MV_LEFT));
            pend_r    <= set_r || (pend_r && !(consume && pick == MV_RIGHT));
        end
    end

    // next state and control strobes; start overrides everything and restarts the piece
    always_comb begin
        state_nx = state;
        spawn    = 1'b0;
        consume  = 1'b0;
        do_latch = 1'b0;
        commit   = 1'b0;
        pick     = pend_fall ? MV_FALL : pend_l ? MV_LEFT : MV_RIGHT;
        nrow     = pick == MV_FALL ? row + 5'd1 : row;
        ncol     = pick == MV_LEFT ? col - 5'd1 : pick == MV_RIGHT ? col + 5'd1 : col;
        case (state)
            SPAWN_CHK: if (occ_valid) state_nx = occ_hit ? OVER : READY;
            READY: if (pend_fall || pend_l || pend_r) begin
                consume = 1'b1;
                if (pick == MV_FALL && row == 5'(ROWS - 1)) state_nx = LOCK;
                else if (!(pick == MV_LEFT && col == 5'd0) && !(pick == MV_RIGHT && col == 5'(COLS - 1))) begin
                    do_latch = 1'b1;
                    state_nx = CHK_MOVE;
                end
            end
            CHK_MOVE: if (occ_valid) begin
                commit   = !occ_hit;
                state_nx = (occ_hit && mv == MV_FALL) ? LOCK : READY;
            end
            LOCK: if (lock_ready) begin
                spawn    = 1'b1;
                state_nx = SPAWN_CHK;
            end
            default: ;
        endcase
        if (start) begin
            spawn    = 1'b1;
            consume  = 1'b0;
            do_latch = 1'b0;
            commit   = 1'b0;
            state_nx = SPAWN_CHK;
        end
    end

    // state, square position and latched move target
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sq_x    <= '0;
            sq_y    <= '0;
            mv      <= MV_FALL;
            tgt_row <= '0;
            tgt_col <= '0;
        end else begin
            state <= state_nx;
            if (spawn) begin
                sq_x <= 10'(SPAWN_X);
                sq_y <= 10'(SPAWN_Y);
            end else if (commit) begin
                sq_y <= mv == MV_FALL ? sq_y + 10'(CELL) : sq_y;
                sq_x <= mv == MV_LEFT ? sq_x - 10'(CELL) : mv == MV_RIGHT ? sq_x + 10'(CELL) : sq_x;
            end
            if (do_latch) begin
                mv      <= pick;
                tgt_row <= nrow;
                tgt_col <= ncol;
            end
        end
    end
endmodule

// File: tb/tb_drop_controller.sv
// tb_drop_controller: scoreboard bench with a board/game reference model and randomized play
module tb_drop_controller;
    localparam int TD = 256;

    logic       clk = 1'b0;
    logic       rst, start, btn_left, btn_right, btn_down;
    logic       occ_valid, occ_hit, lock_ready;
    logic [9:0] sq_x, sq_y;
    logic [4:0] col, row, occ_row, occ_col, lock_row, lock_col;
    logic       occ_req, lock_valid, game_over, busy;

    drop_controller #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .btn_left(btn_left), .btn_right(btn_right),
        .btn_down(btn_down), .sq_x(sq_x), .sq_y(sq_y), .col(col), .row(row),
        .occ_req(occ_req), .occ_row(occ_row), .occ_col(occ_col), .occ_valid(occ_valid),
        .occ_hit(occ_hit), .lock_valid(lock_valid), .lock_row(lock_row), .lock_col(lock_col),
        .lock_ready(lock_ready), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic [4:0] r;
        logic [4:0] c;
    } txn_t;

    txn_t exp_q[$];
    int   rise_t[$];
    bit   board[20][10];
    int   checks = 0, failures = 0;
    int   cyc = 0, last_down = 0, lock_hold = 0;
    int   m_r = 0, m_c = 4;
    bit   m_over = 0, m_started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic txn_t mk(input bit lk, input int r, input int c);
        return txn_t'{lk, 5'(r), 5'(c)};
    endfunction

    task automatic pop_cmp(input bit lk, input logic [4:0] r, input logic [4:0] c);
        txn_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s actual=(%0d,%0d) expected=none", lk ? "lock" : "query", r, c);
        end else begin
            e = exp_q.pop_front();
            chk(lk ? "txn_kind_lock" : "txn_kind_query", 32'(lk), 32'(e.lk));
            chk("txn_row", 32'(r), 32'(e.r));
            chk("txn_col", 32'(c), 32'(e.c));
        end
    endtask

    // board responder and transaction monitor
    initial begin
        int   qwait = 0, lwait = 0;
        bit   prev_req = 0, req_done = 0, held_q = 0, held_l = 0;
        logic [4:0] hr = '0, hc = '0, lr = '0, lc = '0;
        occ_valid  = 0;
        occ_hit    = 0;
        lock_ready = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (occ_req && !prev_req) rise_t.push_back(cyc);
            prev_req = occ_req;
            if (req_done) chk("occ_req_drop", 32'(occ_req), 32'(0));
            req_done  = 0;
            occ_valid = 0;
            occ_hit   = 0;
            if (occ_req) begin
                if (held_q) begin
                    chk("occ_row_stable", 32'(occ_row), 32'(hr));
                    chk("occ_col_stable", 32'(occ_col), 32'(hc));
                end else begin
                    held_q = 1;
                    hr     = occ_row;
                    hc     = occ_col;
                    qwait  = $urandom_range(0, 3);
                end
                if (qwait == 0) begin
                    occ_valid = 1;
                    occ_hit   = (occ_row < 20 && occ_col < 10) ? board[occ_row][occ_col] : 1'b0;
                    pop_cmp(1'b0, occ_row, occ_col);
                    held_q   = 0;
                    req_done = 1;
                end else qwait--;
            end else held_q = 0;
            lock_ready = 0;
            if (lock_valid) begin
                if (held_l) begin
                    chk("lock_row_stable", 32'(lock_row), 32'(lr));
                    chk("lock_col_stable", 32'(lock_col), 32'(lc));
                end else begin
                    held_l = 1;
                    lr     = lock_row;
                    lc     = lock_col;
                    lwait  = lock_hold > 0 ? lock_hold : $urandom_range(0, 3);
                end
                if (lwait == 0) begin
                    lock_ready = 1;
                    pop_cmp(1'b1, lock_row, lock_col);
                    held_l = 0;
                end else lwait--;
            end else held_l = 0;
        end
    end

    task automatic m_spawn();
        m_r = 0;
        m_c = 4;
        exp_q.push_back(mk(0, 0, 4));
        if (board[0][4]) m_over = 1;
    endtask

    task automatic settle();
        int q = 0;
        for (int i = 0; i < 400 && q < 4; i++) begin
            @(negedge clk);
            q = (exp_q.size() == 0 && !occ_req && !lock_valid) ? q + 1 : 0;
        end
        if (q < 4) begin
            checks++;
            failures++;
            $display("FAIL settle_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
        chk("sq_x", 32'(sq_x), 32'(240 + 20 * m_c));
        chk("sq_y", 32'(sq_y), 32'(60 + 20 * m_r));
        chk("col", 32'(col), 32'(m_c));
        chk("row", 32'(row), 32'(m_r));
        chk("busy", 32'(busy), 32'(m_started && !m_over));
        chk("game_over", 32'(game_over), 32'(m_over));
    endtask

    // k: 0 left, 1 right, 2 down, 3 left+right together, 4 start
    task automatic do_event(input int k);
        if (k == 4) begin
            m_over    = 0;
            m_started = 1;
            m_spawn();
        end else if (m_started && !m_over) begin
            if (k == 0 && m_c > 0) begin
                exp_q.push_back(mk(0, m_r, m_c - 1));
                if (!board[m_r][m_c-1]) m_c--;
            end else if (k == 1 && m_c < 9) begin
                exp_q.push_back(mk(0, m_r, m_c + 1));
                if (!board[m_r][m_c+1]) m_c++;
            end else if (k == 2) begin
                last_down = cyc;
                if (m_r < 19) exp_q.push_back(mk(0, m_r + 1, m_c));
                if (m_r < 19 && !board[m_r+1][m_c]) m_r++;
                else begin
                    exp_q.push_back(mk(1, m_r, m_c));
                    board[m_r][m_c] = 1;
                    m_spawn();
                end
            end
        end
        @(negedge clk);
        start     = (k == 4);
        btn_left  = (k == 0 || k == 3);
        btn_right = (k == 1 || k == 3);
        btn_down  = (k == 2);
        @(negedge clk);
        start     = 0;
        btn_left  = 0;
        btn_right = 0;
        btn_down  = 0;
        settle();
    endtask

    task automatic clear_board();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) board[r][c] = 0;
    endtask

    task automatic rand_board();
        clear_board();
        for (int r = 3; r < 20; r++)
            for (int c = 0; c < 10; c++) board[r][c] = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int k;
        rst = 1; start = 0; btn_left = 0; btn_right = 0; btn_down = 0;
        clear_board();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_sq_x", 32'(sq_x), 32'(0));
        chk("rst_sq_y", 32'(sq_y), 32'(0));
        chk("rst_col", 32'(col), 32'(10));
        chk("rst_row", 32'(row), 32'(20));
        chk("rst_occ_req", 32'(occ_req), 32'(0));
        chk("rst_lock_valid", 32'(lock_valid), 32'(0));
        chk("rst_game_over", 32'(game_over), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        board[0][5] = 1;
        board[5][4] = 1;
        do_event(4);
        do_event(1);
        repeat (5) do_event(2);
        repeat (5) do_event(0);
        do_event(3);
        board[1][0] = 1;
        board[0][4] = 1;
        do_event(2);
        do_event(0);
        do_event(1);
        do_event(2);
        clear_board();
        do_event(4);

        for (int n = 0; n < 300; n++) begin
            if (m_over) begin
                rand_board();
                do_event(4);
            end else begin
                k = $urandom_range(0, 9);
                k = k < 3 ? 0 : k < 6 ? 1 : k < 9 ? 2 : 3;
                if (k != 2 && cyc - last_down > 150) k = 2;
                do_event(k);
            end
        end

        clear_board();
        do_event(4);
        do_event(2);
        lock_hold = 5;
        for (int r = m_r + 1; r < 20; r++) exp_q.push_back(mk(0, r, 4));
        exp_q.push_back(mk(1, 19, 4));
        exp_q.push_back(mk(0, 0, 4));
        rise_t.delete();
        for (int i = 0; i < 20 * TD && exp_q.size() > 2; i++) @(negedge clk);
        chk("gravity_falls_left", 32'(exp_q.size()), 32'(2));
        repeat (8) @(negedge clk);
        chk("floor_sq_y", 32'(sq_y), 32'(440));
        chk("floor_row", 32'(row), 32'(19));
        chk("floor_sq_x", 32'(sq_x), 32'(320));
        for (int i = 0; i < 2 * TD && exp_q.size() > 0; i++) @(negedge clk);
        chk("lock_done_pending", 32'(exp_q.size()), 32'(0));
        repeat (4) @(negedge clk);
        chk("respawn_sq_x", 32'(sq_x), 32'(320));
        chk("respawn_sq_y", 32'(sq_y), 32'(60));
        chk("respawn_col", 32'(col), 32'(4));
        chk("respawn_row", 32'(row), 32'(0));
        chk("respawn_busy", 32'(busy), 32'(1));
        chk("gravity_rises", 32'(rise_t.size()), 32'(19));
        for (int i = 0; i < 17 && i + 1 < rise_t.size(); i++)
            chk("tick_period", 32'(rise_t[i+1] - rise_t[i]), 32'(TD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
